// File: rtl/combination_extraction_guarded_if.sv
// combination_extraction_guarded_if: per-lane time-tag input stream and coincidence output stream
interface combination_extraction_guarded_if #(
    parameter int LANE = 4,
    parameter int TIME_TAG_WIDTH = 64,
    parameter int COMB_WIDTH = 16
);
    logic [LANE-1:0][TIME_TAG_WIDTH-1:0] in_timetag;
    logic [LANE-1:0][$clog2(COMB_WIDTH)-1:0] in_channel;
    logic [LANE-1:0] in_valid;
    logic [LANE-1:0][COMB_WIDTH-1:0] out_bitset;
    logic [LANE-1:0][TIME_TAG_WIDTH-1:0] out_first_tag;
    logic [LANE-1:0] out_valid;
    modport master (
        output in_timetag, in_channel, in_valid,
        input out_bitset, out_first_tag, out_valid
    );
    modport slave (
        input in_timetag, in_channel, in_valid,
        output out_bitset, out_first_tag, out_valid
    );
endinterface

// File: rtl/combination_extraction_guarded.sv
// combination_extraction_guarded: groups sorted time tags into guarded clusters and emits qualifying channel bitsets
module combination_extraction_guarded #(
    parameter int LANE = 4,
    parameter int TIME_TAG_WIDTH = 64,
    parameter int COMB_WIDTH = 16,
    parameter int REJECT_REPEAT = 1,
    localparam int CHW = $clog2(COMB_WIDTH),
    localparam int NW = $clog2(COMB_WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic [TIME_TAG_WIDTH-1:0] window,
    input  logic [TIME_TAG_WIDTH-1:0] guard,
    input  logic [COMB_WIDTH-1:0] channel_mask,
    input  logic [NW-1:0] min_channels,
    input  logic [NW-1:0] max_channels,
    combination_extraction_guarded_if.slave bus,
    output logic [31:0] cnt_emitted,
    output logic [31:0] cnt_rejected,
    output logic [31:0] cnt_unsorted
);
    localparam int TW = TIME_TAG_WIDTH;
    localparam int CW = COMB_WIDTH;

    function automatic logic [31:0] sat_add(input logic [31:0] c, input int n);
        logic [32:0] s;
        s = {1'b0, c} + 33'(n);
        return s[32] ? '1 : s[31:0];
    endfunction

    logic [LANE-1:0] acc, bnd, uns;
    logic [TW-1:0] last_tag, last_nxt, prev, diff;
    logic [LANE-1:0] s1_acc, s1_bnd;
    logic [LANE-1:0][TW-1:0] s1_tag;
    logic [LANE-1:0][CHW-1:0] s1_ch;

    // Filter by mask and mark guard boundaries against the previous accepted tag, chained across lanes
    always_comb begin
        acc = '0;
        bnd = '0;
        uns = '0;
        prev = last_tag;
        diff = '0;
        for (int i = 0; i < LANE; i++) begin
            acc[i] = bus.in_valid[i] && channel_mask[bus.in_channel[i]];
            diff = bus.in_timetag[i] - prev;
            bnd[i] = acc[i] && !diff[TW-1] && ($signed(diff) >= $signed(guard));
            uns[i] = acc[i] && diff[TW-1];
            prev = acc[i] ? bus.in_timetag[i] : prev;
        end
        last_nxt = prev;
    end

    // Stage 1 register: precomputed lane flags, running last tag and out-of-order count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_acc <= '0;
            s1_bnd <= '0;
            s1_tag <= '0;
            s1_ch <= '0;
            last_tag <= '0;
            cnt_unsorted <= '0;
        end else begin
            s1_acc <= acc;
            s1_bnd <= bnd;
            s1_tag <= bus.in_timetag;
            s1_ch <= bus.in_channel;
            last_tag <= last_nxt;
            cnt_unsorted <= sat_add(cnt_unsorted, $countones(uns));
        end
    end

    logic [TW-1:0] c_first, c_last, f, l, span;
    logic [CW-1:0] c_bits, b, oh;
    logic c_rep, r, ok;
    logic [NW-1:0] pc;
    logic [LANE-1:0] emit, rej, s2_emit, s2_rej;
    logic [LANE-1:0][CW-1:0] e_bits, s2_bits;
    logic [LANE-1:0][TW-1:0] e_first, s2_first;

    // Walk lanes in order: a boundary commits and qualifies the open cluster, otherwise the event joins it
    always_comb begin
        f = c_first;
        l = c_last;
        b = c_bits;
        r = c_rep;
        emit = '0;
        rej = '0;
        e_bits = '0;
        e_first = '0;
        oh = '0;
        span = '0;
        pc = '0;
        ok = 1'b0;
        for (int i = 0; i < LANE; i++) begin
            oh = CW'(1) << s1_ch[i];
            span = l - f;
            pc = NW'($countones(b));
            ok = ($signed(span) < $signed(window)) && (pc >= min_channels) && (pc <= max_channels)
                 && !((REJECT_REPEAT != 0) && r);
            if (s1_acc[i] && s1_bnd[i]) begin
                emit[i] = (|b) && ok;
                rej[i] = (|b) && !ok;
                e_bits[i] = b;
                e_first[i] = f;
                f = s1_tag[i];
                l = s1_tag[i];
                b = oh;
                r = 1'b0;
            end else if (s1_acc[i]) begin
                r = r || (|(b & oh));
                b = b | oh;
                l = s1_tag[i];
            end
        end
    end

    // Stage 2 register: open cluster state and per-lane commit results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_first <= '0;
            c_last <= '0;
            c_bits <= '0;
            c_rep <= 1'b0;
            s2_emit <= '0;
            s2_rej <= '0;
            s2_bits <= '0;
            s2_first <= '0;
        end else begin
            c_first <= f;
            c_last <= l;
            c_bits <= b;
            c_rep <= r;
            s2_emit <= emit;
            s2_rej <= rej;
            s2_bits <= e_bits;
            s2_first <= e_first;
        end
    end

    // Stage 3 register: outputs and emit/reject statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= '0;
            bus.out_bitset <= '0;
            bus.out_first_tag <= '0;
            cnt_emitted <= '0;
            cnt_rejected <= '0;
        end else begin
            bus.out_valid <= s2_emit;
            bus.out_bitset <= s2_bits;
            bus.out_first_tag <= s2_first;
            cnt_emitted <= sat_add(cnt_emitted, $countones(s2_emit));
            cnt_rejected <= sat_add(cnt_rejected, $countones(s2_rej));
        end
    end
endmodule
